// File: rtl/chrono_pkg.sv
// chrono_pkg: shared state encodings, mode values and clamp helper for chrono_timer
package chrono_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DOWN = 1'b1;
  function automatic logic [5:0] clamp_sec(input logic [5:0] s);
    return s > SEC_MAX ? SEC_MAX : s;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICKS_PER_SEC + 1);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);
  logic [CW-1:0] r_cnt;
  assign tick = en && r_cnt == LAST;
  always_ff @(posedge clk) begin
    if (!rst_n || clr) r_cnt <= '0;
    else if (en) r_cnt <= tick ? '0 : r_cnt + CW'(1);
  end
endmodule

// File: rtl/chrono_timer.sv
// chrono_timer: mm:ss up/down timer with preload, pause, expiry pulse and lap capture.
// Lap capture is built only when CHRONO_LAP_EN is defined; otherwise lap outputs read 0.
module chrono_timer
  import chrono_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int MIN_W = 7,
  parameter int MAX_MIN = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             reset,
  input  logic             mode,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             lap,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic [MIN_W-1:0] lap_min,
  output logic [5:0]       lap_sec,
  output logic             lap_valid,
  output logic             done,
  output logic [1:0]       current_state
);
  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MAX_MIN);
  state_t r_state;
  logic r_mode, r_done;
  logic [MIN_W-1:0] r_min;
  logic [5:0] r_sec;
  logic w_tick, w_load_ok, w_clr, w_zero, w_top, w_hold, w_expire, w_start_ok;
  logic [MIN_W-1:0] w_nxt_min, w_ld_min;
  logic [5:0] w_nxt_sec;
  assign w_load_ok = load && (r_state == ST_IDLE || r_state == ST_PAUSED);
  assign w_clr = reset || w_load_ok || r_state == ST_IDLE || r_state == ST_EXPIRED;
  assign w_zero = r_min == '0 && r_sec == 6'd0;
  assign w_top = r_min == MIN_TOP && r_sec == SEC_MAX;
  // A down run resumed at 0:00 expires on its first tick instead of wrapping
  assign w_hold = r_mode == MODE_UP ? w_top : w_zero;
  assign w_expire = w_hold || (r_mode == MODE_DOWN && r_min == '0 && r_sec == 6'd1);
  assign w_start_ok = start && !stop &&
    (r_state == ST_PAUSED || (r_state == ST_IDLE && !(mode == MODE_DOWN && w_zero)));
  assign w_nxt_sec = w_hold ? r_sec :
    r_mode == MODE_UP ? (r_sec == SEC_MAX ? 6'd0 : r_sec + 6'd1) :
    (r_sec == 6'd0 ? SEC_MAX : r_sec - 6'd1);
  assign w_nxt_min = w_hold ? r_min :
    r_mode == MODE_UP ? (r_sec == SEC_MAX ? r_min + MIN_W'(1) : r_min) :
    (r_sec == 6'd0 ? r_min - MIN_W'(1) : r_min);
  assign w_ld_min = load_min > MIN_TOP ? MIN_TOP : load_min;
  tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (r_state == ST_RUN),
    .clr  (w_clr),
    .tick (w_tick)
  );
  always_ff @(posedge clk) begin
    if (!rst_n || reset) begin
      r_state <= ST_IDLE;
      r_mode <= MODE_UP;
      r_done <= 1'b0;
      r_min <= '0;
      r_sec <= 6'd0;
    end else begin
      r_done <= 1'b0;
      if (w_load_ok) begin
        r_min <= w_ld_min;
        r_sec <= clamp_sec(load_sec);
      end else if (r_state == ST_RUN) begin
        if (w_tick) begin
          r_min <= w_nxt_min;
          r_sec <= w_nxt_sec;
          r_done <= w_expire;
        end
        if (w_tick && w_expire) r_state <= ST_EXPIRED;
        else if (stop) r_state <= ST_PAUSED;
      end else if (w_start_ok) begin
        r_state <= ST_RUN;
        if (r_state == ST_IDLE) r_mode <= mode;
      end
    end
  end
  assign minutes = r_min;
  assign seconds = r_sec;
  assign done = r_done;
  assign current_state = r_state;
`ifdef CHRONO_LAP_EN
  logic [MIN_W-1:0] r_lap_min;
  logic [5:0] r_lap_sec;
  logic r_lap_valid;
  always_ff @(posedge clk) begin
    if (!rst_n || reset) begin
      r_lap_min <= '0;
      r_lap_sec <= 6'd0;
      r_lap_valid <= 1'b0;
    end else if (lap && (r_state == ST_RUN || r_state == ST_PAUSED)) begin
      r_lap_min <= r_min;
      r_lap_sec <= r_sec;
      r_lap_valid <= 1'b1;
    end
  end
  assign lap_min = r_lap_min;
  assign lap_sec = r_lap_sec;
  assign lap_valid = r_lap_valid;
`else
  logic w_unused;
  assign w_unused = lap;
  assign lap_min = '0;
  assign lap_sec = 6'd0;
  assign lap_valid = 1'b0;
`endif
endmodule

// File: tb/tb_chrono_timer.sv
// tb_chrono_timer: randomized scoreboard bench; reference model tracks the count as total seconds
module tb_chrono_timer;
  localparam int T = 2;
  localparam int MAXM = 3;
  localparam int TOP = MAXM * 60 + 59;
`ifdef CHRONO_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif
  typedef struct packed {
    logic [6:0] mi;
    logic [5:0] se;
    logic [6:0] lm;
    logic [5:0] ls;
    logic lv;
    logic dn;
    logic [1:0] st;
  } obs_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, reset = 1'b0, mode = 1'b0, load = 1'b0, lap = 1'b0;
  logic [6:0] load_min = '0, minutes, lap_min;
  logic [5:0] load_sec = '0, seconds, lap_sec;
  logic lap_valid, done;
  logic [1:0] current_state;
  obs_t q[$];
  int n_vec = 0, n_miss = 0;
  int m_tot = 0, m_st = 0, m_ph = 0, m_lap = 0, m_lv = 0;
  bit m_mode = 0, m_done = 0;

  chrono_timer #(.TICKS_PER_SEC(T), .MIN_W(7), .MAX_MIN(MAXM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset), .mode(mode),
    .load(load), .load_min(load_min), .load_sec(load_sec), .lap(lap),
    .minutes(minutes), .seconds(seconds), .lap_min(lap_min), .lap_sec(lap_sec),
    .lap_valid(lap_valid), .done(done), .current_state(current_state)
  );

  always #5 clk = ~clk;

  // States: 0 idle, 1 run, 2 paused, 3 expired; count kept as total seconds
  task automatic model(input logic rn, st, sp, rs, md, ld, input int lm, ls, input logic lp);
    bit run, tk, lok;
    int nst;
    if (!rn || rs) begin
      m_tot = 0; m_st = 0; m_ph = 0; m_mode = 0; m_done = 0; m_lap = 0; m_lv = 0;
      return;
    end
    run = m_st == 1;
    tk = run && m_ph == T - 1;
    lok = ld && (m_st == 0 || m_st == 2);
    m_done = 0;
    if (LAP && lp && (m_st == 1 || m_st == 2)) begin m_lap = m_tot; m_lv = 1; end
    if (lok || m_st == 0 || m_st == 3) m_ph = 0;
    else if (run) m_ph = (m_ph + 1) % T;
    nst = m_st;
    if (lok) m_tot = (lm > MAXM ? MAXM : lm) * 60 + (ls > 59 ? 59 : ls);
    else if (run) begin
      if (tk) begin
        if (!m_mode) begin
          if (m_tot == TOP) m_done = 1; else m_tot++;
        end else begin
          if (m_tot <= 1) begin m_tot = 0; m_done = 1; end else m_tot--;
        end
      end
      if (m_done) nst = 3; else if (sp) nst = 2;
    end else if (st && !sp) begin
      if (m_st == 2) nst = 1;
      else if (m_st == 0 && !(md && m_tot == 0)) begin nst = 1; m_mode = md; end
    end
    m_st = nst;
  endtask

  task automatic cyc(input logic rn, st, sp, rs, md, ld, input logic [6:0] lm, input logic [5:0] ls, input logic lp);
    obs_t e;
    @(negedge clk);
    rst_n = rn; start = st; stop = sp; reset = rs; mode = md; load = ld;
    load_min = lm; load_sec = ls; lap = lp;
    model(rn, st, sp, rs, md, ld, int'(lm), int'(ls), lp);
    e.mi = 7'(m_tot / 60); e.se = 6'(m_tot % 60);
    e.lm = 7'(m_lap / 60); e.ls = 6'(m_lap % 60);
    e.lv = m_lv[0]; e.dn = m_done; e.st = 2'(m_st);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 0, 0, mode, 0, load_min, load_sec, 0);
  endtask

  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {minutes, seconds, lap_min, lap_sec, lap_valid, done, current_state};
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL outputs @%0t: got %0d:%0d lap %0d:%0d v%0b done%0b st%0d, want %0d:%0d lap %0d:%0d v%0b done%0b st%0d",
                   $time, a.mi, a.se, a.lm, a.ls, a.lv, a.dn, a.st, e.mi, e.se, e.lm, e.ls, e.lv, e.dn, e.st);
        end
      end
    end
  end

  initial begin
    logic [6:0] lm;
    cyc(0, 0, 0, 0, 0, 0, 7'd0, 6'd0, 0);
    cyc(0, 1, 0, 0, 0, 1, 7'd5, 6'd5, 1);
    cyc(1, 1, 0, 0, 0, 0, 7'd0, 6'd0, 0);
    idle(124);
    cyc(1, 0, 1, 0, 0, 0, 7'd0, 6'd0, 0);
    idle(20);
    cyc(1, 1, 0, 0, 0, 0, 7'd0, 6'd0, 0);
    idle(4);
    cyc(1, 0, 0, 1, 1, 0, 7'd0, 6'd0, 0);
    cyc(1, 0, 0, 0, 1, 1, 7'd0, 6'd3, 0);
    cyc(1, 1, 0, 0, 1, 0, 7'd0, 6'd3, 0);
    idle(8);
    cyc(1, 1, 1, 0, 1, 1, 7'd2, 6'd2, 0);
    idle(2);
    cyc(1, 0, 0, 1, 0, 0, 7'd0, 6'd0, 0);
    cyc(1, 1, 0, 0, 1, 0, 7'd0, 6'd0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 1, 7'd3, 6'd58, 0);
    cyc(1, 1, 0, 0, 0, 0, 7'd3, 6'd58, 0);
    idle(6);
    cyc(1, 0, 0, 1, 0, 0, 7'd0, 6'd0, 0);
    cyc(1, 0, 0, 0, 0, 1, 7'd120, 6'd63, 0);
    cyc(1, 1, 0, 0, 1, 0, 7'd0, 6'd0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 1, 1, 7'd1, 6'd1, 0);
    idle(2);
    cyc(1, 0, 0, 1, 0, 0, 7'd0, 6'd0, 0);
    cyc(1, 1, 0, 0, 0, 0, 7'd0, 6'd0, 0);
    idle(8);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 7'd0, 6'd0, 1);
    cyc(1, 0, 1, 0, 0, 0, 7'd0, 6'd0, 1);
    cyc(1, 0, 0, 0, 0, 1, 7'd0, 6'd9, 1);
    idle(2);
    cyc(1, 0, 0, 1, 0, 0, 7'd0, 6'd0, 0);
    cyc(1, 1, 1, 0, 0, 0, 7'd0, 6'd0, 0);
    idle(2);
    cyc(1, 1, 0, 0, 0, 0, 7'd0, 6'd0, 0);
    idle(14);
    cyc(0, 0, 0, 0, 0, 0, 7'd0, 6'd0, 0);
    idle(2);
    for (int i = 0; i < 15000; i++) begin
      lm = $urandom_range(0, 1) != 0 ? 7'd0 : 7'($urandom_range(0, 127));
      cyc($urandom_range(0, 399) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0,
          lm, 6'($urandom_range(0, 63)), $urandom_range(0, 7) == 0);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected vectors never observed, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/chrono_timer.md
Name: chrono_timer

Overview:
Parametrised successor to stopwatch_top. Single-clock minutes:seconds timer with up-count (stopwatch) and down-count (countdown) modes, preload, pause/resume, lap capture and an expiry pulse. It sits between the debounced button/control layer and the 7-segment display driver, and replaces stopwatch_top in the next board build.

Parameters:
TICKS_PER_SEC, 100_000_000, clk cycles per one-second tick; must be >= 1.
MIN_W, 7, minutes counter width.
MAX_MIN, 99, largest minutes value; must be <= 2**MIN_W-1.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse: run or resume
stop  in  1  single-cycle pulse: pause
reset  in  1  single-cycle pulse: soft clear to 0:00, IDLE
mode  in  1  0 = up-count, 1 = down-count; sampled only when leaving IDLE
load  in  1  single-cycle pulse: preload the count
load_min  in  MIN_W  preload minutes
load_sec  in  6  preload seconds
lap  in  1  single-cycle pulse: capture the current count
minutes  out  MIN_W  current minutes
seconds  out  6  current seconds, 0..59
lap_min  out  MIN_W  captured minutes
lap_sec  out  6  captured seconds
lap_valid  out  1  high once a lap has been captured
done  out  1  one-cycle pulse on expiry
current_state  out  2  IDLE=0, RUN=1, PAUSED=2, EXPIRED=3

Behaviour:
- Clocking: everything on posedge clk. Reset is synchronous and active-low (rst_n=0 sampled at posedge).
- rst_n=0: all outputs 0, state IDLE, prescaler 0, latched mode 0. The soft reset pulse has the same effect.
- Priority for same-cycle inputs: rst_n > reset > load > stop > start. lap is evaluated independently of the others.
- Prescaler: counts 0..TICKS_PER_SEC-1 only while in RUN. The tick asserts in the cycle where the prescaler equals TICKS_PER_SEC-1.
  - Prescaler holds its value in PAUSED.
  - Prescaler clears on reset, on load, and in IDLE/EXPIRED.
- State transitions:
  - IDLE + start: latch mode, go to RUN.
  - Exception: in down mode with count 0:00, start is ignored and the block stays IDLE.
  - RUN + stop: go to PAUSED. PAUSED + start: go to RUN; the latched mode is kept.
  - EXPIRED: leaves only on reset or rst_n. Start, stop and load are ignored there.
- Up count, per tick:
  - sec+1; at 59 -> sec=0, min+1.
  - A tick while at MAX_MIN:59 leaves the count held (saturates), moves to EXPIRED, and pulses done.
- Down count, per tick:
  - sec-1; at 0 -> sec=59, min-1.
  - The tick that produces 0:00 moves to EXPIRED and pulses done in that same update cycle.
- done: high for exactly one cycle, registered alongside the final count.
- Load: accepted in IDLE or PAUSED only.
  - Clamps load_sec>59 to 59 and load_min>MAX_MIN to MAX_MIN.
  - Count updates the next cycle. Load is ignored in RUN.
- Lap: accepted in RUN or PAUSED.
  - lap_min/lap_sec register the pre-update count; on a simultaneous tick, the value before the tick is captured.
  - lap_valid=1 from then until reset or rst_n.
  - Later laps overwrite the captured value.
- Stop while IDLE or PAUSED and start while RUN: no effect.
- Output latency: a count change is visible 1 cycle after the tick cycle.

Optional Feature:
CHRONO_LAP_EN
- Defined: lap capture as specified above.
- Undefined: the lap input is ignored; lap_min, lap_sec and lap_valid are tied to 0. Ports remain, so the interface is unchanged.

Decomposition:
- Package chrono_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSED, ST_EXPIRED;
  - SEC_MAX=59;
  - MODE_UP=0, MODE_DOWN=1.
- Sub-module tick_prescaler (param TICKS_PER_SEC; ports clk, rst_n, en, clr, tick) is instantiated once.
- Count update and FSM stay in chrono_timer.

Test Plan:
1. TICKS_PER_SEC=2, mode=0: start, run 122 cycles -> 1:01, state RUN; stop, wait 20 cycles -> still 1:01, state PAUSED; start, 4 cycles -> 1:03.
2. mode=1: load 0:03, start, 6 cycles -> 0:00, done=1 for exactly one cycle, state EXPIRED; start again -> ignored; reset -> 0:00, IDLE.
3. MAX_MIN=1, mode=0: load 1:58 in IDLE, start, 4 cycles -> 1:59, state EXPIRED, done pulse, count held at 1:59.
4. Load with load_sec=63, load_min=120 (MAX_MIN=99) -> count 99:59. Load during RUN -> count unchanged.
5. With CHRONO_LAP_EN: lap in the tick cycle at 0:04 -> lap=0:04, lap_valid=1, display 0:05. Without the macro -> lap outputs stay 0.
6. Simultaneous start+stop in IDLE -> stays IDLE. rst_n=0 mid-RUN at 0:07 -> all outputs 0 on the next posedge.
